// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: MIPS branch opcodes, REGIMM rt codes and shared helpers
package branch_ctrl_pkg;
    localparam logic [5:0]  REGIMM_INST  = 6'b000001;
    localparam logic [5:0]  BEQ          = 6'b000100;
    localparam logic [5:0]  BNE          = 6'b000101;
    localparam logic [5:0]  BLEZ         = 6'b000110;
    localparam logic [5:0]  BGTZ         = 6'b000111;
    localparam logic [4:0]  BLTZ         = 5'b00000;
    localparam logic [4:0]  BGEZ         = 5'b00001;
    localparam logic [4:0]  BLTZAL       = 5'b10000;
    localparam logic [4:0]  BGEZAL       = 5'b10001;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam int          WAIT_MAX_DEF = 15;

    function automatic logic [31:0] br_target(input logic [31:0] pc4, input logic [15:0] imm);
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // single-operand branches never look at rt readiness
    function automatic logic rs_only(input logic [5:0] op);
        return op == BLEZ || op == BGTZ || op == REGIMM_INST;
    endfunction
endpackage

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: decode/hazard/fetch signals around the branch sequencer
interface branch_ctrl_if;
    logic        br_valid_d;
    logic [5:0]  opD;
    logic [4:0]  rtD;
    logic [31:0] a;
    logic [31:0] b;
    logic        rs_rdy;
    logic        rt_rdy;
    logic [31:0] pc_plus4_d;
    logic [15:0] imm_d;
    logic        flush;
    logic        redirect_ready;
    logic        stall_d;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        link_en;
    logic [31:0] link_addr;
    logic        wait_err;
    logic [31:0] br_cnt;
    logic [31:0] taken_cnt;

    modport master (
        output br_valid_d, opD, rtD, a, b, rs_rdy, rt_rdy, pc_plus4_d, imm_d, flush, redirect_ready,
        input  stall_d, redirect_valid, redirect_target, link_en, link_addr, wait_err, br_cnt, taken_cnt
    );

    modport slave (
        input  br_valid_d, opD, rtD, a, b, rs_rdy, rt_rdy, pc_plus4_d, imm_d, flush, redirect_ready,
        output stall_d, redirect_valid, redirect_target, link_en, link_addr, wait_err, br_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_ctrl_br_cond.sv
// br_cond: combinational branch condition and link decode
module br_cond
    import branch_ctrl_pkg::*;
(
    input  logic [5:0]  opD,
    input  logic [4:0]  rtD,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        taken,
    output logic        is_link
);
    logic regimm;
    logic a_zero;

    // unknown opcodes and REGIMM sub-ops fall through to not taken
    always_comb begin
        regimm  = opD == REGIMM_INST;
        a_zero  = a == ZeroWord;
        is_link = regimm & (rtD == BGEZAL | rtD == BLTZAL);
        taken   = opD == BEQ  ? a == b :
                  opD == BNE  ? a != b :
                  opD == BGTZ ? !a[31] & !a_zero :
                  opD == BLEZ ? a[31] | a_zero :
                  !regimm     ? 1'b0 :
                  (rtD == BGEZ | rtD == BGEZAL) ? !a[31] :
                  (rtD == BLTZ | rtD == BLTZAL) ? a[31] : 1'b0;
    end
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: decode-stage branch sequencer with operand wait and fetch redirect
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic         clk,
    input  logic         resetn,
    branch_ctrl_if.slave bus
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT_OPND, REDIRECT} state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] wcnt;
    logic [31:0]   target;
    logic [31:0]   br_cnt;
    logic [31:0]   taken_cnt;
    logic          taken;
    logic          is_link;
    logic          rdy;
    logic          eval;

    br_cond u_cond (
        .opD     (bus.opD),
        .rtD     (bus.rtD),
        .a       (bus.a),
        .b       (bus.b),
        .taken   (taken),
        .is_link (is_link)
    );

    assign rdy = bus.rs_rdy & (rs_only(bus.opD) | bus.rt_rdy);

    // next state and evaluate strobe; IDLE and WAIT_OPND resolve a branch identically
    always_comb begin
        eval = 1'b0;
        nxt  = state;
        if (state == REDIRECT) begin
            nxt = bus.redirect_ready ? IDLE : REDIRECT;
        end else begin
            eval = bus.br_valid_d & rdy;
            nxt  = !bus.br_valid_d ? IDLE : !rdy ? WAIT_OPND : taken ? REDIRECT : IDLE;
        end
        if (bus.flush) begin
            eval = 1'b0;
            nxt  = IDLE;
        end
    end

    assign bus.stall_d         = resetn & bus.br_valid_d & (state == REDIRECT | !rdy);
    assign bus.redirect_valid  = state == REDIRECT & !bus.flush;
    assign bus.redirect_target = target;
    assign bus.link_en         = resetn & eval & is_link;
    assign bus.link_addr       = bus.link_en ? bus.pc_plus4_d + 32'd4 : ZeroWord;
    assign bus.wait_err        = resetn & !bus.flush & state == WAIT_OPND & bus.br_valid_d & !rdy
                                 & wcnt == CW'(WAIT_MAX - 1);
    assign bus.br_cnt          = br_cnt;
    assign bus.taken_cnt       = taken_cnt;

    // state, saturating wait counter, latched target and perf counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            wcnt      <= '0;
            target    <= ZeroWord;
            br_cnt    <= ZeroWord;
            taken_cnt <= ZeroWord;
        end else begin
            state <= nxt;
            wcnt  <= (state == WAIT_OPND && nxt == WAIT_OPND) ?
                     (wcnt == CW'(WAIT_MAX) ? wcnt : wcnt + 1'b1) : '0;
            if (eval)
                br_cnt <= br_cnt + 32'd1;
            if (eval & taken) begin
                target    <= br_target(bus.pc_plus4_d, bus.imm_d);
                taken_cnt <= taken_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed and randomized checks of branch_ctrl against a transaction model
module tb_branch_ctrl;
    import branch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_br = 0;
    logic [31:0] exp_tk = 0;
    logic [4:0]  rts [5] = '{BLTZ, BGEZ, BLTZAL, BGEZAL, 5'b00011};

    branch_ctrl_if bif();

    branch_ctrl #(.WAIT_MAX(15)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    wire [3:0] fl = {bif.stall_d, bif.redirect_valid, bif.link_en, bif.wait_err};

    always #5 clk = ~clk;

    function automatic bit m_taken(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] av, input logic [31:0] bv);
        if (op == BEQ) return av == bv;
        if (op == BNE) return av != bv;
        if (op == BGTZ) return $signed(av) > 0;
        if (op == BLEZ) return $signed(av) <= 0;
        if (op == REGIMM_INST && (rt == BGEZ || rt == BGEZAL)) return $signed(av) >= 0;
        if (op == REGIMM_INST && (rt == BLTZ || rt == BLTZAL)) return $signed(av) < 0;
        return 0;
    endfunction

    function automatic bit m_link(input logic [5:0] op, input logic [4:0] rt);
        return op == REGIMM_INST && (rt == BGEZAL || rt == BLTZAL);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc, input logic [15:0] imm);
        logic signed [31:0] off;
        off = $signed(imm);
        return pc + off * 4;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rt, input logic [31:0] av,
                         input logic [31:0] bv, input logic rs, input logic rtr, input logic [31:0] pc,
                         input logic [15:0] imm, input logic rr);
        bif.br_valid_d     = v;
        bif.opD            = op;
        bif.rtD            = rt;
        bif.a              = av;
        bif.b              = bv;
        bif.rs_rdy         = rs;
        bif.rt_rdy         = rtr;
        bif.pc_plus4_d     = pc;
        bif.imm_d          = imm;
        bif.redirect_ready = rr;
        bif.flush          = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(0, 6'd0, 5'd0, 0, 0, 0, 0, 0, 16'd0, 0);
        repeat (2) cyc();
        checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", fl); end
        checks++; if (bif.redirect_target !== 32'd0) begin failures++; $display("FAIL reset_target got=%h exp=0", bif.redirect_target); end
        checks++; if (bif.br_cnt !== 32'd0 || bif.taken_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%h/%h exp=0/0", bif.br_cnt, bif.taken_cnt); end
        checks++; if (bif.link_addr !== 32'd0) begin failures++; $display("FAIL reset_link_addr got=%h exp=0", bif.link_addr); end
        resetn = 1'b1;
        cyc();
        checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL reset_release got=%b exp=0000", fl); end
        exp_br = 0;
        exp_tk = 0;
    endtask

    task automatic test_beq_taken();
        cyc();
        drive(1, BEQ, 5'd0, 5, 5, 1, 1, 32'h100, 16'h0004, 1);
        #1;
        checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL beq_n_flags got=%b exp=0000", fl); end
        exp_br++; exp_tk++;
        cyc();
        bif.br_valid_d = 0;
        #1;
        checks++; if (fl !== 4'b0100) begin failures++; $display("FAIL beq_n1_flags got=%b exp=0100", fl); end
        checks++; if (bif.redirect_target !== 32'h110) begin failures++; $display("FAIL beq_target got=%h exp=110", bif.redirect_target); end
        checks++; if (bif.br_cnt !== 32'd1 || bif.taken_cnt !== 32'd1) begin failures++; $display("FAIL beq_cnt got=%0d/%0d exp=1/1", bif.br_cnt, bif.taken_cnt); end
        cyc();
        checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL beq_n2_flags got=%b exp=0000", fl); end
    endtask

    task automatic test_bne_not_taken();
        cyc();
        drive(1, BNE, 5'd0, 7, 7, 1, 1, 32'h200, 16'h0010, 1);
        #1;
        checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL bne_flags got=%b exp=0000", fl); end
        exp_br++;
        cyc();
        bif.br_valid_d = 0;
        #1;
        checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL bne_no_redirect got=%b exp=0000", fl); end
        checks++; if (bif.br_cnt !== exp_br || bif.taken_cnt !== exp_tk) begin failures++; $display("FAIL bne_cnt got=%0d/%0d exp=%0d/%0d", bif.br_cnt, bif.taken_cnt, exp_br, exp_tk); end
    endtask

    task automatic test_bltzal_wait();
        for (int i = 0; i < 3; i++) begin
            cyc();
            drive(1, REGIMM_INST, BLTZAL, 32'h8000_0000, 0, 0, 0, 32'h400, 16'hFFFE, 1);
            #1;
            checks++; if (fl !== 4'b1000) begin failures++; $display("FAIL bltzal_wait%0d got=%b exp=1000", i, fl); end
        end
        cyc();
        bif.rs_rdy = 1;
        #1;
        checks++; if (fl !== 4'b0010) begin failures++; $display("FAIL bltzal_eval got=%b exp=0010", fl); end
        checks++; if (bif.link_addr !== 32'h404) begin failures++; $display("FAIL bltzal_link_addr got=%h exp=404", bif.link_addr); end
        exp_br++; exp_tk++;
        cyc();
        bif.br_valid_d = 0;
        #1;
        checks++; if (fl !== 4'b0100) begin failures++; $display("FAIL bltzal_redirect got=%b exp=0100", fl); end
        checks++; if (bif.redirect_target !== 32'h3F8) begin failures++; $display("FAIL bltzal_target got=%h exp=3f8", bif.redirect_target); end
        cyc();
        checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL bltzal_done got=%b exp=0000", fl); end
    endtask

    task automatic test_neg_offset();
        cyc();
        drive(1, BEQ, 5'd0, 1, 1, 1, 1, 32'h0001_0000, 16'h8000, 0);
        #1;
        exp_br++; exp_tk++;
        for (int i = 0; i < 4; i++) begin
            cyc();
            drive(1, BEQ, 5'd0, 3, 4, 1, 1, 32'h0002_0000, 16'h0020, 0);
            #1;
            checks++; if (fl !== 4'b1100) begin failures++; $display("FAIL neg_hold%0d got=%b exp=1100", i, fl); end
            checks++; if (bif.redirect_target !== 32'hFFFF_0000) begin failures++; $display("FAIL neg_target%0d got=%h exp=ffff0000", i, bif.redirect_target); end
            checks++; if (bif.br_cnt !== exp_br) begin failures++; $display("FAIL neg_no_eval%0d got=%0d exp=%0d", i, bif.br_cnt, exp_br); end
        end
        cyc();
        bif.redirect_ready = 1;
        #1;
        checks++; if (fl !== 4'b1100) begin failures++; $display("FAIL neg_handshake got=%b exp=1100", fl); end
        cyc();
        checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL neg_second_eval got=%b exp=0000", fl); end
        exp_br++;
        cyc();
        bif.br_valid_d = 0;
        #1;
        checks++; if (bif.br_cnt !== exp_br || bif.taken_cnt !== exp_tk) begin failures++; $display("FAIL neg_cnt got=%0d/%0d exp=%0d/%0d", bif.br_cnt, bif.taken_cnt, exp_br, exp_tk); end
    endtask

    task automatic test_flush();
        cyc();
        drive(1, BNE, 5'd0, 1, 2, 1, 1, 32'h300, 16'h0008, 0);
        #1;
        exp_br++; exp_tk++;
        cyc();
        bif.br_valid_d = 0;
        #1;
        checks++; if (fl !== 4'b0100) begin failures++; $display("FAIL flush_pre_redirect got=%b exp=0100", fl); end
        bif.flush = 1;
        cyc();
        bif.flush = 0;
        #1;
        checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL flush_redirect got=%b exp=0000", fl); end
        checks++; if (bif.br_cnt !== exp_br || bif.taken_cnt !== exp_tk) begin failures++; $display("FAIL flush_redirect_cnt got=%0d/%0d exp=%0d/%0d", bif.br_cnt, bif.taken_cnt, exp_br, exp_tk); end
        cyc();
        drive(1, REGIMM_INST, BGEZAL, 5, 0, 0, 0, 32'h500, 16'h0004, 1);
        #1;
        checks++; if (fl !== 4'b1000) begin failures++; $display("FAIL flush_wait_stall got=%b exp=1000", fl); end
        cyc();
        cyc();
        bif.rs_rdy = 1;
        bif.flush = 1;
        #1;
        checks++; if (bif.link_en !== 1'b0) begin failures++; $display("FAIL flush_wait_link got=%b exp=0", bif.link_en); end
        cyc();
        bif.flush = 0;
        bif.br_valid_d = 0;
        #1;
        checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL flush_wait_idle got=%b exp=0000", fl); end
        checks++; if (bif.br_cnt !== exp_br || bif.taken_cnt !== exp_tk) begin failures++; $display("FAIL flush_wait_cnt got=%0d/%0d exp=%0d/%0d", bif.br_cnt, bif.taken_cnt, exp_br, exp_tk); end
        cyc();
        drive(1, BEQ, 5'd0, 9, 9, 1, 1, 32'h600, 16'h0004, 1);
        bif.flush = 1;
        cyc();
        drive(0, BEQ, 5'd0, 9, 9, 1, 1, 32'h600, 16'h0004, 1);
        #1;
        checks++; if (fl !== 4'b0000 || bif.br_cnt !== exp_br) begin failures++; $display("FAIL flush_idle got=%b/%0d exp=0000/%0d", fl, bif.br_cnt, exp_br); end
    endtask

    task automatic test_wait_err();
        int pulses = 0;
        int idx = -1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            drive(1, BLEZ, 5'd0, 0, 0, 0, 1, 32'h700, 16'h0004, 1);
            #1;
            if (bif.wait_err === 1'b1) begin
                pulses++;
                idx = i;
            end
            checks++; if (bif.stall_d !== 1'b1) begin failures++; $display("FAIL wait_stall%0d got=%b exp=1", i, bif.stall_d); end
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL wait_err_count got=%0d exp=1", pulses); end
        checks++; if (idx !== 15) begin failures++; $display("FAIL wait_err_cycle got=%0d exp=15", idx); end
        cyc();
        bif.rs_rdy = 1;
        #1;
        checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL wait_release got=%b exp=0000", fl); end
        exp_br++; exp_tk++;
        cyc();
        bif.br_valid_d = 0;
        #1;
        checks++; if (fl !== 4'b0100 || bif.redirect_target !== 32'h710) begin failures++; $display("FAIL wait_redirect got=%b/%h exp=0100/710", fl, bif.redirect_target); end
        cyc();
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            logic [5:0]  op;
            logic [4:0]  rt;
            logic [31:0] av, bv, pc;
            logic [15:0] imm;
            int          s, k, d;
            bit          need_rt, tk, lk, nb;
            s   = $urandom_range(0, 6);
            op  = s == 0 ? BEQ : s == 1 ? BNE : s == 2 ? BGTZ : s == 3 ? BLEZ : s < 6 ? REGIMM_INST : 6'b000010;
            rt  = rts[$urandom_range(0, 4)];
            s   = $urandom_range(0, 3);
            av  = s == 0 ? 32'd0 : s == 1 ? (32'h8000_0000 | $urandom) : $urandom;
            bv  = $urandom_range(0, 1) ? av : $urandom;
            pc  = $urandom & 32'hFFFF_FFFC;
            imm = 16'($urandom);
            k   = $urandom_range(0, 3);
            d   = $urandom_range(0, 3);
            need_rt = !(op inside {BLEZ, BGTZ, REGIMM_INST});
            tk  = m_taken(op, rt, av, bv);
            lk  = m_link(op, rt);
            for (int i = 0; i < k; i++) begin
                cyc();
                if (need_rt && $urandom_range(0, 1))
                    drive(1, op, rt, av, bv, 1, 0, pc, imm, 0);
                else
                    drive(1, op, rt, av, bv, 0, 1'($urandom), pc, imm, 0);
                #1;
                checks++; if (fl !== 4'b1000) begin failures++; $display("FAIL rnd%0d_wait got=%b exp=1000", t, fl); end
            end
            cyc();
            drive(1, op, rt, av, bv, 1, need_rt ? 1'b1 : 1'($urandom), pc, imm, 1'($urandom));
            #1;
            checks++; if (fl !== {2'b00, lk, 1'b0}) begin failures++; $display("FAIL rnd%0d_eval op=%h rt=%h got=%b exp=%b", t, op, rt, fl, {2'b00, lk, 1'b0}); end
            if (lk) begin
                checks++; if (bif.link_addr !== pc + 32'd4) begin failures++; $display("FAIL rnd%0d_link_addr got=%h exp=%h", t, bif.link_addr, pc + 32'd4); end
            end
            exp_br++;
            if (tk) begin
                exp_tk++;
                for (int j = 0; j <= d; j++) begin
                    cyc();
                    nb = 1'($urandom);
                    bif.br_valid_d = nb;
                    bif.rs_rdy = 1;
                    bif.rt_rdy = 1;
                    bif.redirect_ready = j == d;
                    #1;
                    checks++; if (fl !== {nb, 1'b1, 2'b00}) begin failures++; $display("FAIL rnd%0d_redirect got=%b exp=%b", t, fl, {nb, 1'b1, 2'b00}); end
                    checks++; if (bif.redirect_target !== m_target(pc, imm)) begin failures++; $display("FAIL rnd%0d_target got=%h exp=%h", t, bif.redirect_target, m_target(pc, imm)); end
                end
            end
            cyc();
            bif.br_valid_d = 0;
            #1;
            checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL rnd%0d_after got=%b exp=0000", t, fl); end
            checks++; if (bif.br_cnt !== exp_br || bif.taken_cnt !== exp_tk) begin failures++; $display("FAIL rnd%0d_cnt got=%0d/%0d exp=%0d/%0d", t, bif.br_cnt, bif.taken_cnt, exp_br, exp_tk); end
        end
    endtask

    task automatic test_reset_mid_redirect();
        cyc();
        drive(1, BEQ, 5'd0, 2, 2, 1, 1, 32'h800, 16'h0004, 0);
        cyc();
        bif.br_valid_d = 0;
        #1;
        checks++; if (fl !== 4'b0100) begin failures++; $display("FAIL rst_mid_pre got=%b exp=0100", fl); end
        #2;
        resetn = 0;
        #1;
        checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL rst_mid_flags got=%b exp=0000", fl); end
        checks++; if (bif.br_cnt !== 32'd0 || bif.taken_cnt !== 32'd0 || bif.redirect_target !== 32'd0) begin failures++; $display("FAIL rst_mid_regs got=%h/%h/%h exp=0/0/0", bif.br_cnt, bif.taken_cnt, bif.redirect_target); end
        exp_br = 0;
        exp_tk = 0;
        cyc();
        resetn = 1;
        cyc();
        checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL rst_mid_after got=%b exp=0000", fl); end
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_bltzal_wait();
        test_neg_offset();
        test_flush();
        test_wait_err();
        test_random();
        test_reset_mid_redirect();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Decode-stage branch sequencer for the MIPS core with the sram-like fetch interface. Accepts conditional branches from decode, stalls decode until both operands are forwardable, and evaluates the condition through the `br_cond` comparator. It then holds a PC redirect until the fetch unit acknowledges it, and reports link writes for the AL variants. It sits between the hazard unit, the decode register and the fetch/PC unit.

## Interface
- `WAIT_MAX`, 15: operand-wait cycles before `wait_err` pulses.
- `clk` in 1: core clock.
- `resetn` in 1: asynchronous, active-low reset.
- `br_valid_d` in 1: decode holds a conditional branch (BEQ/BNE/BGTZ/BLEZ/REGIMM).
- `opD` in 6: opcode of the decode instruction.
- `rtD` in 5: rt field (REGIMM sub-op).
- `a`, `b` in 32: forwarded rs / rt values.
- `rs_rdy`, `rt_rdy` in 1: hazard unit says the operand value is final this cycle.
- `pc_plus4_d` in 32: PC+4 of the branch.
- `imm_d` in 16: branch offset.
- `flush` in 1: exception/eret flush; aborts any pending work.
- `redirect_ready` in 1: fetch accepts a redirect (delay slot fetched, no outstanding request).
- `stall_d` out 1: hold decode and fetch stages.
- `redirect_valid` out 1: redirect request.
- `redirect_target` out 32: new PC.
- `link_en` out 1: one-cycle pulse; write `link_addr` to $31.
- `link_addr` out 32: PC+8 of the branch.
- `wait_err` out 1: one-cycle pulse on operand-wait timeout (debug only).
- `br_cnt`, `taken_cnt` out 32: resolved / taken branch counters.

## Operation
- States: IDLE, WAIT_OPND, REDIRECT.
- IDLE:
  - `br_valid_d` with `rs_rdy & rt_rdy`: evaluate. `br_cnt`+1. `link_en` pulses if BGEZAL/BLTZAL, taken or not.
  - Taken: latch target, `taken_cnt`+1, go to REDIRECT. Not taken: stay in IDLE.
  - Operands not ready: go to WAIT_OPND, `stall_d`=1.
  - BLEZ/BGTZ/REGIMM need only `rs_rdy`; `rt_rdy` is ignored for them.
- WAIT_OPND:
  - `stall_d`=1, wait counter increments.
  - Once the required operands are ready: `stall_d`=0 that cycle, evaluate exactly as in IDLE, then go to REDIRECT or IDLE.
  - Counter reaching `WAIT_MAX`: `wait_err` pulses once; keep waiting; counter saturates.
- REDIRECT:
  - `redirect_valid`=1; `redirect_target` is held stable.
  - Leave to IDLE on `redirect_valid & redirect_ready`.
  - A new `br_valid_d` arriving while in REDIRECT gets `stall_d`=1 and is not evaluated until IDLE.
- Condition decode (in `br_cond`):
  - BEQ: a==b. BNE: a!=b.
  - BGTZ: !a[31] & a!=0. BLEZ: a[31] | a==0.
  - BGEZ/BGEZAL: !a[31]. BLTZ/BLTZAL: a[31].
  - Any other op/rt: not taken, no link, still counted in `br_cnt`.
- Arithmetic:
  - target = `pc_plus4_d` + (sign-extend(`imm_d`) << 2), 32-bit modulo.
  - `link_addr` = `pc_plus4_d` + 4, modulo.
  - Counters wrap at 2^32.
- `flush` in any state: go to IDLE next cycle; drop `redirect_valid`; clear the wait counter; no counter update; suppress `link_en`. `flush` wins over a same-cycle evaluation.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0; counters 0; target 0.
- Ready operands: decision in cycle N; `redirect_valid` first high in N+1; `link_en` in N (combinational from registered state plus inputs).
- Minimum redirect duration: 1 cycle (ready already high in N+1). `redirect_valid` never drops without a handshake or `flush`.
- `stall_d` is combinational from state and ready inputs; no added latency on release.
- Reset mid-REDIRECT: the redirect is lost; fetch restarts from the reset vector.

## Structure
- Opcode and REGIMM rt codes (`BEQ`, `BNE`, `BGTZ`, `BLEZ`, `REGIMM_INST`, `BGEZ`, `BLTZ`, `BGEZAL`, `BLTZAL`) and `ZeroWord` come from the shared defines header.
- The state encoding localparams stay local to this module.
- One sub-module, `br_cond`: purely combinational; produces taken and is_link from `opD`, `rtD`, `a`, `b`.
- The FSM, target adder, wait counter and perf counters live in `branch_ctrl`.

## Test plan
- BEQ, a=b=5, both ready, `pc_plus4_d`=0x100, `imm_d`=0x0004, `redirect_ready`=1 → `redirect_valid` high exactly cycle N+1 with target 0x110; `br_cnt`=1, `taken_cnt`=1.
- BNE, a=b, ready → no redirect, `stall_d`=0, `br_cnt`+1, `taken_cnt` unchanged.
- BLTZAL, a=0x80000000, `rs_rdy` low 3 cycles → `stall_d` high 3 cycles; on ready, `link_en` pulses with `link_addr`=PC+8; redirect issued.
- `imm_d`=0x8000, `pc_plus4_d`=0x00010000 → target 0xFFFF0000 (negative offset, sign extension). `redirect_ready` low 4 cycles → target stable, `redirect_valid` held, and a second branch in decode is stalled until the handshake.
- `flush` asserted during REDIRECT and during WAIT_OPND → IDLE next cycle, `redirect_valid` 0, no `link_en`. With `rs_rdy` held low 16 cycles → exactly one `wait_err` pulse.
- `resetn` low asynchronously while in REDIRECT → all outputs 0 immediately; counters 0.
